ps2_kbd_port: RTL and testbench
===============================

Name: ps2_kbd_port

Overview:
Wishbone B3 responder that receives PS/2 keyboard frames on N2_PS2C_I/N2_PS2D_I and presents the scancodes to the CPU.
- Frame path: synchroniser, glitch filter, frame decoder, FIFO.
- Decoded bytes are buffered in a FIFO and read through a 16-bit, two-register port.
- It is the input-side companion to the CPU-written LED/VGA output port.
- It decodes at address 4'h2xxx on the STEAMER16X4 bus.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (depth 16 bytes).
FILTER_LEN, 8, number of consecutive clk_i cycles a synchronised PS/2 clock level must hold before it is accepted.
TIMEOUT, 50000, maximum clk_i cycles between accepted PS/2 falling edges inside a frame (1 ms at 50 MHz).

Ports:
clk_i  in  1  system clock (50 MHz)
res_i  in  1  reset, asynchronous assert, active-low
adr_i  in  1  word address bit [1]: 0=DATA, 1=STATUS
cyc_i  in  1  Wishbone cycle
stb_i  in  1  Wishbone strobe (qualified externally by the address decode)
we_i  in  1  write enable
sel_i  in  2  byte selects
dat_i  in  16  write data
dat_o  out  16  read data
ack_o  out  1  acknowledge
ps2c_i  in  1  raw PS/2 clock
ps2d_i  in  1  raw PS/2 data
irq_o  out  1  FIFO non-empty

Behaviour:
Reset (res_i=0, async):
- ack_o=0, irq_o=0, dat_o=0.
- FIFO empty, all sticky flags 0.
- Decoder in IDLE, filter output 1.

Bus handshake:
- ack_o <= ~ack_o & cyc_i & stb_i, giving exactly one wait state per access, with back-to-back accesses alternating.
- dat_o is combinational from adr_i and is valid while ack_o=1.

DATA register (adr_i=0), read:
- [7:0] = FIFO head byte, [8] = non-empty, [15:9] = 0.
- A read with sel_i[0]=1 pops on the edge where ack_o=1, if the FIFO is non-empty.
- Reading while empty returns [8]=0, no pop.
- Writes to DATA are acknowledged and ignored.

STATUS register (adr_i=1), read:
- [0] non-empty, [1] full, [2] parity err, [3] framing err, [4] overrun, [5] timeout.
- [12:8] count (0..16), others 0.

STATUS register, write with sel_i[0]=1 on the ack edge:
- Bits [5:2] are write-1-to-clear.
- bit [7]=1 flushes the FIFO (count=0).
- Sticky set and clear in the same cycle: set wins.

Input conditioning:
- ps2c_i and ps2d_i each pass through a 2-FF synchroniser.
- Filtered clock changes only after FILTER_LEN stable samples.
- A falling edge of the filtered clock is the sample strobe; data is sampled from the synchronised ps2d.

Decoder FSM (states IDLE, DATA, PARITY, STOP):
- IDLE: on strobe, if data=0 go to DATA with bit counter=0; if data=1 stay (spurious start, no flag).
- DATA: shift LSB-first on each strobe; after the 8th bit go to PARITY.
- PARITY: capture the bit and go to STOP.
- STOP: go to IDLE. If stop=1 and odd parity holds (XOR of 8 data bits and parity bit = 1), push the byte.
- STOP errors: if stop=0, set framing err with no push; else if parity is bad, set parity err with no push.
- Timeout: a counter resets on each strobe and runs outside IDLE. Reaching TIMEOUT aborts to IDLE, sets timeout, and discards the partial byte.

FIFO:
- Circular, FIFO_AW-bit pointers, count width FIFO_AW+1.
- Push while full with no pop the same cycle: byte dropped, overrun set.
- Push and pop in the same cycle: both occur, count unchanged, legal even when full.
- Flush and push in the same cycle: flush wins, count=0.
- irq_o is registered: it equals non-empty, one cycle after count changes.

Optional Feature:
Macro PS2_INHIBIT_EN.
- Defined: adds output ps2c_oe_o (1 bit, reset 0). It drives 1, pulling the PS/2 clock low through the external open-drain pad, whenever count >= 2^FIFO_AW - 1 and the decoder is in IDLE. It releases one cycle after count drops below that threshold, so the keyboard holds keys instead of overrunning.
- Undefined: the port does not exist and overrun behaviour stands as above.

Test Plan:
- Reset then STATUS read: dat_o=16'h0000, irq_o=0; ack_o high exactly 1 cycle after cyc_i&stb_i.
- Send frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1): irq_o=1, STATUS[12:8]=1, DATA read returns 16'h011C, then count=0 and irq_o=0.
- Send 0x1C with parity 1: no push, STATUS=16'h0004; write STATUS 16'h0004 → STATUS=16'h0000.
- Send 17 valid frames 0x00..0x10 without reading: count=16, full=1, overrun=1; 16 reads return 0x00..0x0F in order.
- Stop after 4 data bits and idle for 50000 cycles: timeout=1, count unchanged; the next full frame 0x5A decodes correctly.
- 3-cycle low glitch on ps2c_i in IDLE with FILTER_LEN=8: no state change, no flags set.

Source files
------------

// File: rtl/ps2_kbd_port_if.sv
// Wishbone B3 bus bundle for the PS/2 keyboard port: the CPU is the master and the port is the slave.
interface ps2_kbd_port_if;
    logic        adr_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack_o;

    modport master (output adr_i, cyc_i, stb_i, we_i, sel_i, dat_i, input  dat_o, ack_o);
    modport slave  (input  adr_i, cyc_i, stb_i, we_i, sel_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver: synchroniser, glitch filter, frame decoder and scancode FIFO behind a Wishbone port.
// Optional macro PS2_INHIBIT_EN adds ps2c_oe_o, which holds the PS/2 clock low while the FIFO is nearly full.
module ps2_kbd_port #(
    parameter int FIFO_AW    = 4,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic          clk_i,
    input  logic          res_i,
    ps2_kbd_port_if.slave bus,
    input  logic          ps2c_i,
    input  logic          ps2d_i,
`ifdef PS2_INHIBIT_EN
    output logic          ps2c_oe_o,
`endif
    output logic          irq_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic               ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
    logic               filt_p2, vld_p2, dsmp_p2;
    logic [FLT_W-1:0]   flt_cnt;
    state_t             state, state_nxt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               par_bit;
    logic [TO_W-1:0]    to_cnt;
    logic               to_hit, push, set_par, set_frm, set_to, set_ovr;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         mem [DEPTH];
    logic               full, nonempty, pop, push_ok, wr_stat, flush;
    logic               err_par, err_frm, err_ovr, err_to;
    logic [3:0]         clr;
    logic               unused_bits;

    // p0/p1: two-flop synchronisers, idle-high
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= ps2c_i;
            ps2c_p1 <= ps2c_p0;
            ps2d_p0 <= ps2d_i;
            ps2d_p1 <= ps2d_p0;
        end
    end

    // p2: filtered clock; vld_p2 pulses on an accepted falling edge
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            filt_p2 <= 1'b1;
            flt_cnt <= '0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (ps2c_p1 == filt_p2) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                filt_p2 <= ps2c_p1;
                flt_cnt <= '0;
                vld_p2  <= ~ps2c_p1;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) dsmp_p2 <= ps2d_p1;

    assign to_hit = (state != IDLE) && !vld_p2 && (to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        set_par   = 1'b0;
        set_frm   = 1'b0;
        set_to    = 1'b0;
        if (to_hit) begin
            state_nxt = IDLE;
            set_to    = 1'b1;
        end else if (vld_p2) begin
            case (state)
                IDLE:    if (!dsmp_p2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (!dsmp_p2)               set_frm = 1'b1;
                    else if (^{shreg, par_bit}) push    = 1'b1;
                    else                        set_par = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || vld_p2) to_cnt <= '0;
            else                         to_cnt <= to_cnt + TO_W'(1);
            if (vld_p2 && state == IDLE)      bit_cnt <= '0;
            else if (vld_p2 && state == DATA) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (vld_p2 && state == DATA)   shreg   <= {dsmp_p2, shreg[7:1]};
        if (vld_p2 && state == PARITY) par_bit <= dsmp_p2;
    end

    // Bus side: pops and status writes take effect on the edge where ack_o is high
    assign nonempty = (count != '0);
    assign full     = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop      = bus.ack_o & ~bus.we_i & ~bus.adr_i & bus.sel_i[0] & nonempty;
    assign wr_stat  = bus.ack_o & bus.we_i & bus.adr_i & bus.sel_i[0];
    assign flush    = wr_stat & bus.dat_i[7];
    assign push_ok  = push & (~full | pop);
    assign set_ovr  = push & full & ~pop & ~flush;
    assign clr      = wr_stat ? bus.dat_i[5:2] : 4'b0000;

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) mem[wr_ptr] <= shreg;
    end

    // Sticky flags: a set in the same cycle as its clear wins
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            err_par <= 1'b0;
            err_frm <= 1'b0;
            err_ovr <= 1'b0;
            err_to  <= 1'b0;
            irq_o   <= 1'b0;
            bus.ack_o <= 1'b0;
        end else begin
            err_par <= (err_par & ~clr[0]) | set_par;
            err_frm <= (err_frm & ~clr[1]) | set_frm;
            err_ovr <= (err_ovr & ~clr[2]) | set_ovr;
            err_to  <= (err_to  & ~clr[3]) | set_to;
            irq_o   <= nonempty;
            bus.ack_o <= ~bus.ack_o & bus.cyc_i & bus.stb_i;
        end
    end

`ifdef PS2_INHIBIT_EN
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) ps2c_oe_o <= 1'b0;
        else        ps2c_oe_o <= (count >= (FIFO_AW + 1)'(DEPTH - 1)) && (state == IDLE);
    end
`endif

    always_comb begin
        bus.dat_o = '0;
        if (bus.adr_i) begin
            bus.dat_o[0]               = nonempty;
            bus.dat_o[1]               = full;
            bus.dat_o[2]               = err_par;
            bus.dat_o[3]               = err_frm;
            bus.dat_o[4]               = err_ovr;
            bus.dat_o[5]               = err_to;
            bus.dat_o[8 +: FIFO_AW+1]  = count;
        end else begin
            bus.dat_o[8] = nonempty;
            if (nonempty) bus.dat_o[7:0] = mem[rd_ptr];
        end
    end

    assign unused_bits = ^{bus.sel_i[1], bus.dat_i[15:8], bus.dat_i[6], bus.dat_i[1:0]};
endmodule

// File: tb/tb_ps2_kbd_port.sv
// Self-checking bench for ps2_kbd_port: PS/2 keyboard model, Wishbone master tasks and a scancode scoreboard.
module tb_ps2_kbd_port;
    logic clk = 1'b0;
    logic res_i;
    logic ps2c_i, ps2d_i, irq_o;
`ifdef PS2_INHIBIT_EN
    logic ps2c_oe_o;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    ps2_kbd_port_if bus ();

    ps2_kbd_port dut (
        .clk_i     (clk),
        .res_i     (res_i),
        .bus       (bus.slave),
        .ps2c_i    (ps2c_i),
        .ps2d_i    (ps2d_i),
`ifdef PS2_INHIBIT_EN
        .ps2c_oe_o (ps2c_oe_o),
`endif
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Keyboard model: data changes mid clock-high, 20-cycle low and high phases
    task automatic ps2_bit(input logic b);
        ps2d_i = b;
        repeat (10) @(negedge clk);
        ps2c_i = 1'b0;
        repeat (20) @(negedge clk);
        ps2c_i = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic par_flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
        ps2_bit(1'b1);
        repeat (40) @(negedge clk);
    endtask

    task automatic wb_xfer(input logic we, input logic adr, input logic [15:0] wd, output logic [15:0] rd);
        int n;
        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.sel_i = 2'b01;
        bus.dat_i = wd;
        n  = 0;
        rd = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ack_o !== 1'b1 && n < 8);
        if (bus.ack_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout got ack=%b required 1", bus.ack_o);
        end else begin
            rd = bus.dat_o;
        end
        @(posedge clk);
        #1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
    endtask

    task automatic test_reset();
        res_i = 1'b0;
        bus.adr_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b required 0", bus.ack_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b required 0", irq_o); end
        checks++; if (bus.dat_o !== 16'h0000) begin errors++; $display("FAIL reset_dat got %h required 0000", bus.dat_o); end
        res_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 1'b1;
        #1;
        checks++; if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL ack_early got %b required 0", bus.ack_o); end
        @(posedge clk);
        #1;
        checks++; if (bus.ack_o !== 1'b1) begin errors++; $display("FAIL ack_one_wait got %b required 1", bus.ack_o); end
        checks++; if (bus.dat_o !== 16'h0000) begin errors++; $display("FAIL status_after_reset got %h required 0000", bus.dat_o); end
        @(posedge clk);
        #1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
    endtask

    task automatic test_frame();
        logic [15:0] rd;
        logic [7:0]  exp;
        int n;
        ps2_frame(8'h1C, 1'b0);
        sb_q.push_back(8'h1C);
        n = 0;
        while (irq_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL frame_irq got %b required 1", irq_o); end
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0101) begin errors++; $display("FAIL frame_status got %h required 0101", rd); end
        wb_xfer(1'b0, 1'b0, 16'h0000, rd);
        exp = sb_q.pop_front();
        checks++; if (rd !== {7'b0, 1'b1, exp}) begin errors++; $display("FAIL frame_data got %h required %h", rd, {7'b0, 1'b1, exp}); end
        repeat (2) @(negedge clk);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL frame_irq_clear got %b required 0", irq_o); end
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL frame_status_empty got %h required 0000", rd); end
    endtask

    task automatic test_parity_err();
        logic [15:0] rd;
        ps2_frame(8'h1C, 1'b1);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL parity_status got %h required 0004", rd); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL parity_irq got %b required 0", irq_o); end
        wb_xfer(1'b1, 1'b1, 16'h0004, rd);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL parity_w1c got %h required 0000", rd); end
    endtask

    task automatic test_overrun();
        logic [15:0] rd;
        logic [7:0]  exp;
        for (int i = 0; i < 17; i++) begin
            ps2_frame(8'(i), 1'b0);
            if (i < 16) sb_q.push_back(8'(i));
        end
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h1013) begin errors++; $display("FAIL overrun_status got %h required 1013", rd); end
`ifdef PS2_INHIBIT_EN
        checks++; if (ps2c_oe_o !== 1'b1) begin errors++; $display("FAIL inhibit_on got %b required 1", ps2c_oe_o); end
`endif
        for (int i = 0; i < 16; i++) begin
            wb_xfer(1'b0, 1'b0, 16'h0000, rd);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (rd !== {7'b0, 1'b1, exp}) begin errors++; $display("FAIL overrun_read%0d got %h required %h", i, rd, {7'b0, 1'b1, exp}); end
        end
        repeat (2) @(negedge clk);
`ifdef PS2_INHIBIT_EN
        checks++; if (ps2c_oe_o !== 1'b0) begin errors++; $display("FAIL inhibit_off got %b required 0", ps2c_oe_o); end
`endif
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0010) begin errors++; $display("FAIL overrun_drained got %h required 0010", rd); end
        wb_xfer(1'b1, 1'b1, 16'h0010, rd);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL overrun_w1c got %h required 0000", rd); end
    endtask

    task automatic test_timeout();
        logic [15:0] rd;
        logic [7:0]  exp;
        logic [7:0]  part;
        part = 8'h5A;
        ps2_frame(8'h33, 1'b0);
        sb_q.push_back(8'h33);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        repeat (50200) @(negedge clk);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0121) begin errors++; $display("FAIL timeout_status got %h required 0121", rd); end
        wb_xfer(1'b1, 1'b1, 16'h0020, rd);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0101) begin errors++; $display("FAIL timeout_w1c got %h required 0101", rd); end
        ps2_frame(8'h5A, 1'b0);
        sb_q.push_back(8'h5A);
        for (int i = 0; i < 2; i++) begin
            wb_xfer(1'b0, 1'b0, 16'h0000, rd);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            checks++;
            if (rd !== {7'b0, 1'b1, exp}) begin errors++; $display("FAIL timeout_read%0d got %h required %h", i, rd, {7'b0, 1'b1, exp}); end
        end
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL timeout_final got %h required 0000", rd); end
    endtask

    task automatic test_glitch();
        logic [15:0] rd;
        logic [7:0]  exp;
        ps2d_i = 1'b0;
        repeat (5) @(negedge clk);
        ps2c_i = 1'b0;
        repeat (3) @(negedge clk);
        ps2c_i = 1'b1;
        repeat (20) @(negedge clk);
        ps2d_i = 1'b1;
        repeat (20) @(negedge clk);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL glitch_status got %h required 0000", rd); end
        ps2_frame(8'hA5, 1'b0);
        sb_q.push_back(8'hA5);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0101) begin errors++; $display("FAIL glitch_next_status got %h required 0101", rd); end
        wb_xfer(1'b0, 1'b0, 16'h0000, rd);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        checks++; if (rd !== {7'b0, 1'b1, exp}) begin errors++; $display("FAIL glitch_next_data got %h required %h", rd, {7'b0, 1'b1, exp}); end
    endtask

    task automatic test_flush();
        logic [15:0] rd;
        ps2_frame(8'h11, 1'b0);
        ps2_frame(8'h22, 1'b0);
        sb_q.push_back(8'h11);
        sb_q.push_back(8'h22);
        wb_xfer(1'b1, 1'b0, 16'hFFFF, rd);
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0201) begin errors++; $display("FAIL flush_before got %h required 0201", rd); end
        wb_xfer(1'b1, 1'b1, 16'h0080, rd);
        sb_q.delete();
        wb_xfer(1'b0, 1'b1, 16'h0000, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL flush_after got %h required 0000", rd); end
        @(negedge clk);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL flush_irq got %b required 0", irq_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'b0000;
        @(negedge clk);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat = {pat[2:0], bus.ack_o};
        end
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL b2b_ack_pattern got %b required 1010", pat); end
    endtask

    initial begin
        res_i     = 1'b0;
        ps2c_i    = 1'b1;
        ps2d_i    = 1'b1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = 1'b0;
        bus.sel_i = 2'b01;
        bus.dat_i = 16'h0000;
        test_reset();
        test_frame();
        test_parity_err();
        test_overrun();
        test_glitch();
        test_flush();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
